hazard_ctrl_unit: RTL and testbench

Next-generation hazard controller for the 5-stage in-order pipeline (F/D/E/M/WB).
- Generates forwarding selects, per-stage stall and flush controls.
- Handles RAW and load-use hazards, control-transfer redirects, and variable-latency data memory.
- Parametrised forwarding mode; adds a memory-wait timeout monitor and saturating hazard performance counters.

---
 rtl/hazard_ctrl_unit.sv | 143 ++++++++++++++
 tb/tb_hazard_ctrl_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_unit.sv
// Hazard controller for a 5-stage in-order pipeline: operand forwarding selects,
// per-stage stall/flush controls, memory-wait timeout monitor and hazard counters.
module hazard_ctrl_unit #(
  parameter int REG_AW   = 5,
  parameter int FWD_EN   = 1,
  parameter int MAX_WAIT = 64,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rs1D,
  input  logic [REG_AW-1:0] rs2D,
  input  logic              rs1_usedD,
  input  logic              rs2_usedD,
  input  logic [REG_AW-1:0] rs1E,
  input  logic [REG_AW-1:0] rs2E,
  input  logic [REG_AW-1:0] rdE,
  input  logic [REG_AW-1:0] rdM,
  input  logic [REG_AW-1:0] rdWB,
  input  logic              rd_wrenE,
  input  logic              rd_wrenM,
  input  logic              rd_wrenWB,
  input  logic              is_loadE,
  input  logic              is_loadM,
  input  logic              mem_reqM,
  input  logic              mem_rdyM,
  input  logic              redirectE,
  input  logic              clr_cnt,
  output logic [1:0]        forw_a_sel,
  output logic [1:0]        forw_b_sel,
  output logic              stallF,
  output logic              stallD,
  output logic              stallE,
  output logic              stallM,
  output logic              flushD,
  output logic              flushE,
  output logic              flushWB,
  output logic              timeout_err,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  logic [REG_AW-1:0] rs_d [2];
  logic [REG_AW-1:0] rs_e [2];
  logic [1:0]        used_d;
  logic [1:0]        fwd_sel [2];
  logic [1:0]        raw_hit;

  assign rs_d[0] = rs1D;
  assign rs_d[1] = rs2D;
  assign rs_e[0] = rs1E;
  assign rs_e[1] = rs2E;
  assign used_d  = {rs2_usedD, rs1_usedD};

  // Destination qualifiers shared by both source lanes; x0 is never a producer.
  logic live_e, live_m, live_wb;
  assign live_e  = rd_wrenE  && (rdE  != '0);
  assign live_m  = rd_wrenM  && (rdM  != '0);
  assign live_wb = rd_wrenWB && (rdWB != '0);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      logic m_hit, wb_hit, load_use, any_raw;
      // A load in M has no result yet, so only ALU results forward from M.
      assign m_hit    = live_m && (rdM == rs_e[gi]) && !is_loadM;
      assign wb_hit   = live_wb && (rdWB == rs_e[gi]);
      assign load_use = used_d[gi] && live_e && is_loadE && (rdE == rs_d[gi]);
      assign any_raw  = used_d[gi] && ((live_e && (rdE == rs_d[gi])) ||
                                       (live_m && (rdM == rs_d[gi])));

      assign fwd_sel[gi] = (FWD_EN == 0) ? 2'b00 :
                           m_hit         ? 2'b10 :
                           wb_hit        ? 2'b01 : 2'b00;
      assign raw_hit[gi] = (FWD_EN != 0) ? load_use : any_raw;
    end
  endgenerate

  assign forw_a_sel = fwd_sel[0];
  assign forw_b_sel = fwd_sel[1];

  logic memwait, redirect, rawstall;

  // Priority: memory wait freezes everything, then a redirect squashes the
  // wrong-path instruction in D, and only then a D-stage RAW stall applies.
  always_comb begin
    memwait  = mem_reqM && !mem_rdyM;
    redirect = redirectE && !memwait;
    rawstall = (|raw_hit) && !memwait && !redirect;

    stallF  = memwait || rawstall;
    stallD  = memwait || rawstall;
    stallE  = memwait;
    stallM  = memwait;
    flushD  = redirect;
    flushE  = redirect || rawstall;
    flushWB = memwait;
  end

  logic [WAIT_W-1:0] wait_cnt_reg;
  logic              timeout_err_reg;
  logic [CNT_W-1:0]  stall_cnt_reg;
  logic [CNT_W-1:0]  flush_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_reg    <= '0;
      timeout_err_reg <= 1'b0;
      stall_cnt_reg   <= '0;
      flush_cnt_reg   <= '0;
    end else begin
      if (memwait) begin
        if (wait_cnt_reg != WAIT_LAST) begin
          wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
        end else begin
          timeout_err_reg <= 1'b1;
        end
      end else begin
        wait_cnt_reg <= '0;
      end

      if (clr_cnt) begin
        stall_cnt_reg <= '0;
        flush_cnt_reg <= '0;
      end else begin
        if (stallF && (stall_cnt_reg != '1)) begin
          stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
        end
        if (redirect && (flush_cnt_reg != '1)) begin
          flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
        end
      end
    end
  end

  assign timeout_err = timeout_err_reg;
  assign stall_cnt   = stall_cnt_reg;
  assign flush_cnt   = flush_cnt_reg;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Scoreboard bench: two controller instances (forwarding / no forwarding) share
// stimulus; expectations are queued per cycle and checked by a separate monitor.
module tb_hazard_ctrl_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdWB;
  logic       rs1_usedD, rs2_usedD, rd_wrenE, rd_wrenM, rd_wrenWB;
  logic       is_loadE, is_loadM, mem_reqM, mem_rdyM, redirectE, clr_cnt;

  logic [1:0]  fa1, fb1, fa0, fb0;
  logic        sF1, sD1, sE1, sM1, fD1, fE1, fW1, to1;
  logic        sF0, sD0, sE0, sM0, fD0, fE0, fW0, to0;
  logic [3:0]  sc1, fc1;
  logic [15:0] sc0, fc0;

  hazard_ctrl_unit #(.REG_AW(5), .FWD_EN(1), .MAX_WAIT(4), .CNT_W(4)) u1 (
    .clk(clk), .rst(rst), .rs1D(rs1D), .rs2D(rs2D), .rs1_usedD(rs1_usedD),
    .rs2_usedD(rs2_usedD), .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE), .rdM(rdM),
    .rdWB(rdWB), .rd_wrenE(rd_wrenE), .rd_wrenM(rd_wrenM), .rd_wrenWB(rd_wrenWB),
    .is_loadE(is_loadE), .is_loadM(is_loadM), .mem_reqM(mem_reqM),
    .mem_rdyM(mem_rdyM), .redirectE(redirectE), .clr_cnt(clr_cnt),
    .forw_a_sel(fa1), .forw_b_sel(fb1), .stallF(sF1), .stallD(sD1),
    .stallE(sE1), .stallM(sM1), .flushD(fD1), .flushE(fE1), .flushWB(fW1),
    .timeout_err(to1), .stall_cnt(sc1), .flush_cnt(fc1));

  hazard_ctrl_unit #(.REG_AW(5), .FWD_EN(0), .MAX_WAIT(64), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .rs1D(rs1D), .rs2D(rs2D), .rs1_usedD(rs1_usedD),
    .rs2_usedD(rs2_usedD), .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE), .rdM(rdM),
    .rdWB(rdWB), .rd_wrenE(rd_wrenE), .rd_wrenM(rd_wrenM), .rd_wrenWB(rd_wrenWB),
    .is_loadE(is_loadE), .is_loadM(is_loadM), .mem_reqM(mem_reqM),
    .mem_rdyM(mem_rdyM), .redirectE(redirectE), .clr_cnt(clr_cnt),
    .forw_a_sel(fa0), .forw_b_sel(fb0), .stallF(sF0), .stallD(sD0),
    .stallE(sE0), .stallM(sM0), .flushD(fD0), .flushE(fE0), .flushWB(fW0),
    .timeout_err(to0), .stall_cnt(sc0), .flush_cnt(fc0));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observable selectors for scoreboard entries.
  localparam int S_FA1 = 0, S_FB1 = 1, S_CTL1 = 2, S_TO1 = 3, S_SC1 = 4,
                 S_FC1 = 5, S_CTL0 = 6, S_SC0 = 7, S_FA0 = 8;

  // Control vector order: {stallF, stallD, stallE, stallM, flushD, flushE, flushWB}
  localparam logic [15:0] C_IDLE = 16'b0000000;
  localparam logic [15:0] C_RAW  = 16'b1100010;
  localparam logic [15:0] C_REDR = 16'b0000110;
  localparam logic [15:0] C_WAIT = 16'b1111001;

  typedef struct {
    int          cyc;
    int          sel;
    logic [15:0] exp;
    string       name;
  } item_t;

  item_t sbq[$];
  int total = 0;
  int bad   = 0;

  function automatic logic [15:0] actual(int sel);
    case (sel)
      S_FA1:  return {14'd0, fa1};
      S_FB1:  return {14'd0, fb1};
      S_CTL1: return {9'd0, sF1, sD1, sE1, sM1, fD1, fE1, fW1};
      S_TO1:  return {15'd0, to1};
      S_SC1:  return {12'd0, sc1};
      S_FC1:  return {12'd0, fc1};
      S_CTL0: return {9'd0, sF0, sD0, sE0, sM0, fD0, fE0, fW0};
      S_SC0:  return sc0;
      S_FA0:  return {14'd0, fa0};
      default: return 16'hdead;
    endcase
  endfunction

  task automatic expect_now(string name, int sel, logic [15:0] v);
    item_t it;
    it.cyc = cyc; it.sel = sel; it.exp = v; it.name = name;
    sbq.push_back(it);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rs1D = 0; rs2D = 0; rs1_usedD = 0; rs2_usedD = 0; rs1E = 0; rs2E = 0;
    rdE = 0; rdM = 0; rdWB = 0; rd_wrenE = 0; rd_wrenM = 0; rd_wrenWB = 0;
    is_loadE = 0; is_loadM = 0; mem_reqM = 0; mem_rdyM = 0; redirectE = 0;
    clr_cnt = 0;
  endtask

  task automatic load_use(logic used);
    is_loadE = 1; rdE = 7; rd_wrenE = 1; rs1D = 7; rs1_usedD = used;
  endtask

  // Monitor: compares every entry due in the current cycle, mid-cycle.
  always @(negedge clk) begin
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].cyc <= cyc) begin
        logic [15:0] a;
        a = actual(sbq[i].sel);
        total++;
        if (a !== sbq[i].exp) begin
          bad++;
          $display("FAIL %s cyc=%0d got=%0h want=%0h", sbq[i].name, cyc, a, sbq[i].exp);
        end else begin
          $display("check %s cyc=%0d value=%0h", sbq[i].name, cyc, a);
        end
        sbq.delete(i);
      end
    end
  end

  initial begin
    idle();
    rst = 1;
    step(); step();
    rst = 0;
    expect_now("rst_to", S_TO1, 0);
    expect_now("rst_sc1", S_SC1, 0);
    expect_now("rst_fc1", S_FC1, 0);
    expect_now("rst_sc0", S_SC0, 0);
    expect_now("rst_ctl", S_CTL1, C_IDLE);

    // Forwarding priority and qualifiers
    step(); rdM = 5; rd_wrenM = 1; rdWB = 5; rd_wrenWB = 1; rs1E = 5; rs2E = 5;
    expect_now("fwd_m_a", S_FA1, 2'b10);
    expect_now("fwd_m_b", S_FB1, 2'b10);
    expect_now("fwd_off_a", S_FA0, 2'b00);
    expect_now("fwd_noctl", S_CTL1, C_IDLE);
    step(); is_loadM = 1;
    expect_now("fwd_ldm_a", S_FA1, 2'b01);
    expect_now("fwd_ldm_b", S_FB1, 2'b01);
    step(); is_loadM = 0; rdM = 0; rs2E = 0;
    expect_now("fwd_rdm0_a", S_FA1, 2'b01);
    expect_now("fwd_x0_b", S_FB1, 2'b00);
    step(); is_loadM = 1; rdWB = 0;
    expect_now("fwd_none_a", S_FA1, 2'b00);

    // Load-use: one bubble, then cleared by the flushed E
    step(); idle(); load_use(1);
    expect_now("lu_stall1", S_CTL1, C_RAW);
    expect_now("lu_stall0", S_CTL0, C_RAW);
    step(); idle(); rs1D = 7; rs1_usedD = 1;
    expect_now("lu_clear", S_CTL1, C_IDLE);
    expect_now("lu_cnt", S_SC1, 1);
    step(); idle(); load_use(0);
    expect_now("lu_unused1", S_CTL1, C_IDLE);
    expect_now("lu_unused0", S_CTL0, C_IDLE);
    step(); idle(); load_use(1); redirectE = 1;
    expect_now("redir_beats_raw1", S_CTL1, C_REDR);
    expect_now("redir_beats_raw0", S_CTL0, C_REDR);
    step(); idle(); clr_cnt = 1;
    expect_now("pre_clr_fc1", S_FC1, 1);
    expect_now("pre_clr_sc0", S_SC0, 1);
    step(); idle();
    expect_now("clr_sc1", S_SC1, 0);
    expect_now("clr_fc1", S_FC1, 0);
    expect_now("clr_sc0", S_SC0, 0);

    // No forwarding: RAW against M stalls every cycle until it clears
    step(); idle(); rdM = 3; rd_wrenM = 1; rs1D = 3; rs1_usedD = 1;
    expect_now("nofwd_c1", S_CTL0, C_RAW);
    expect_now("fwd_nostall", S_CTL1, C_IDLE);
    step();
    expect_now("nofwd_c2", S_CTL0, C_RAW);
    step(); rdM = 0;
    expect_now("nofwd_drop", S_CTL0, C_IDLE);
    expect_now("nofwd_cnt", S_SC0, 2);
    expect_now("fwd_cnt0", S_SC1, 0);

    // Memory wait suppresses redirect until the access completes
    for (int i = 0; i < 3; i++) begin
      step(); idle(); mem_reqM = 1; redirectE = 1;
      expect_now("mw_ctl", S_CTL1, C_WAIT);
    end
    expect_now("mw3_to", S_TO1, 0);
    step(); mem_rdyM = 1;
    expect_now("mw_done_redir", S_CTL1, C_REDR);
    expect_now("mw_sc1", S_SC1, 3);
    step(); idle();
    expect_now("mw_fc1", S_FC1, 1);
    expect_now("mw_no_to", S_TO1, 0);

    // Timeout after MAX_WAIT consecutive waits, sticky until reset
    for (int i = 0; i < 4; i++) begin
      step(); idle(); mem_reqM = 1;
      expect_now("to_pending", S_TO1, 0);
    end
    step(); idle();
    expect_now("to_set", S_TO1, 1);
    expect_now("to_sc1", S_SC1, 7);
    step();
    expect_now("to_sticky", S_TO1, 1);
    step(); rst = 1;
    expect_now("to_pre_rst", S_TO1, 1);
    step(); rst = 0;
    expect_now("to_rst", S_TO1, 0);
    expect_now("to_rst_sc1", S_SC1, 0);

    // Stall counter saturation (4-bit instance) and clear-over-increment
    for (int i = 0; i < 16; i++) begin
      step(); idle(); load_use(1);
      expect_now("sat_ramp", S_SC1, 16'(i));
    end
    step();
    expect_now("sat_hold", S_SC1, 15);
    step(); clr_cnt = 1;
    expect_now("sat_pre_clr", S_SC1, 15);
    step(); clr_cnt = 0; idle();
    expect_now("sat_clr", S_SC1, 0);

    for (int i = 0; i < 5 && sbq.size() != 0; i++) step();
    if (sbq.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain pending=%0d want=0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
